seg_scan_ctrl: RTL
==================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clock cycles per digit slot, including the gap.
REQ-002 SHALL have parameter GAP_CYC, default 16: blanking cycles at the start of each slot; legal range 1 <= GAP_CYC < CLK_DIV.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: scan enable; when low, the display is dark.
REQ-006 SHALL have port data_in, input, 16 bits: four hex digits; digit0 is data_in[3:0].
REQ-007 SHALL have port load, input, 1 bit: single-cycle request to capture data_in.
REQ-008 SHALL have port lz_en, input, 1 bit: leading-zero suppression enable.
REQ-009 SHALL have port dp_in, input, 4 bits: per-digit decimal point, active-high.
REQ-010 SHALL have port an, output, 4 bits: digit anodes, active-low, registered.
REQ-011 SHALL have port a_to_g, output, 7 bits: segments g..a, active-low, registered.
REQ-012 SHALL have port dp, output, 1 bit: decimal point, active-low, registered.
REQ-013 SHALL have port ack, output, 1 bit: one-cycle pulse when pending data is committed to the display.
REQ-014 SHALL have port busy, output, 1 bit: high while a load is pending commit.

Function
REQ-015 SHALL use state machine states OFF, GAP and ON.
- OFF: entered whenever en=0.
- OFF->GAP(digit0) on the first cycle en=1.
- GAP lasts GAP_CYC cycles, then ->ON.
- ON lasts CLK_DIV-GAP_CYC cycles, then ->GAP(digit idx+1 mod 4).
REQ-016 SHALL, when en goes low in any state, move to OFF on the next edge and clear the prescaler and the digit index to 0.
REQ-017 SHALL drive an to all-ones during OFF and GAP, and drive an[idx] low (others high) during ON.
REQ-018 SHALL present outputs with 1-cycle latency from state/idx; segments for idx are valid throughout that slot's GAP.
REQ-019 SHALL, on load=1, write data_in into the pending register and set busy.
REQ-020 SHALL overwrite the pending register on repeated loads before commit; only the last value is committed, with one ack.
REQ-021 SHALL treat the frame boundary as the cycle of entry into GAP(digit0), including from OFF. At the boundary, if busy: display register <= pending, busy cleared, ack=1 for exactly 1 cycle.
REQ-022 SHALL, when load coincides with a boundary: commit the previous pending value (if any) and keep the new data pending, with busy held at 1.
REQ-023 SHALL produce no ack at the boundary when busy=0.
REQ-024 SHALL, with lz_en=1, blank digit i (i=3..1) to a_to_g=7'h7F when display digits 3..i are all zero; digit0 is never blanked.
REQ-025 SHALL drive dp = ~dp_in[idx], independent of blanking.
REQ-026 SHALL use a prescaler width of ceil(log2(CLK_DIV)) bits that wraps to 0 at each slot end; idx is 2 bits and wraps 3->0.

Reset
REQ-027 SHALL, while clr=1, immediately and asynchronously set: an=4'hF, a_to_g=7'h7F, dp=1, ack=0, busy=0, state=OFF, idx=0, prescaler=0, display and pending registers=0.
REQ-028 SHALL, after clr deasserts with en=1, start at GAP(digit0) as a frame boundary with no ack; a load in progress when clr asserts is discarded.

Structure
REQ-029 SHALL place the state encoding (OFF/GAP/ON) and the blank segment constant 7'h7F in the shared display package.
REQ-030 SHALL instantiate the existing hex-to-segment decoder x7seg, one instance muxed by idx, whose active-low outputs [6:0] feed a_to_g. The blanking override is applied outside the decoder.

Verification (CLK_DIV=8, GAP_CYC=2)
REQ-031 SHALL cover: load 16'h12AF, en=1 -> one ack at the next boundary. Each slot shows an=1111 for 2 cycles, then the digit for 6 cycles. Segment values per digit:
- digit0 an=1110, a_to_g=7'h0E
- digit1 an=1101, a_to_g=7'h08
- digit2 an=1011, a_to_g=7'h24
- digit3 an=0111, a_to_g=7'h79
REQ-032 SHALL cover: lz_en=1, data 16'h0005 -> digits 3..1 a_to_g=7'h7F and digit0 7'h12. Data 16'h0000 -> digit0 7'h40, others blank.
REQ-033 SHALL cover: loads of 16'h1111 then 16'h2222 within one frame -> a single ack, and all digits show 7'h24.
REQ-034 SHALL cover: load asserted on a boundary cycle while busy=1 -> old value commits with ack, busy stays 1, and the new value commits with ack one frame (32 cycles) later.
REQ-035 SHALL cover: clr pulse mid-ON -> an=4'hF and a_to_g=7'h7F within the same cycle. en dropped mid-slot -> an=4'hF after 1 edge; on re-enable, a 2-cycle GAP precedes digit0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display definitions for the 4-digit seven-segment scan controller.
// Holds the scan state encoding, dark-output constants and the leading-zero helper.
package seg_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF = 2'd0,
      ST_GAP = 2'd1,
      ST_ON  = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'hF;

   // Digit idx is a leading zero when it and every digit above it are zero.
   // Digit 0 always shows, so a zero value still displays as a single "0".
   function automatic logic lz_blank(input logic [15:0] disp, input logic [1:0] idx);
      logic blank;
      blank = 1'b0;
      case (idx)
         2'd3:    blank = (disp[15:12] == 4'h0);
         2'd2:    blank = (disp[15:8]  == 8'h00);
         2'd1:    blank = (disp[15:4]  == 12'h000);
         default: blank = 1'b0;
      endcase
      return blank;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_x7seg.sv
// Hex digit to seven-segment decoder; outputs are active-low, ordered g..a.
module x7seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with a blanking gap per
// slot, frame-synchronous data commit and optional leading-zero suppression.
//
//   state | meaning
//   OFF   | scan disabled, display dark, prescaler and digit index held at 0
//   GAP   | anodes off for GAP_CYC cycles while segments settle on the new digit
//   ON    | anode idx driven for CLK_DIV-GAP_CYC cycles
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int GAP_CYC = 16
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   input  logic [15:0] data_in,
   input  logic        load,
   input  logic        lz_en,
   input  logic [3:0]  dp_in,
   output logic [3:0]  an,
   output logic [6:0]  a_to_g,
   output logic        dp,
   output logic        ack,
   output logic        busy
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYC - 1);
   localparam logic [PW-1:0] SLOT_LAST = PW'(CLK_DIV - 1);

   scan_state_e   state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   pend_q, pend_d;
   logic [15:0]   disp_q, disp_d;
   logic          busy_q, busy_d;
   logic          ack_q, ack_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          frame_start;
   logic [3:0]    digit_sel;
   logic [6:0]    seg_raw;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_OFF;
         presc_q <= '0;
         idx_q   <= 2'd0;
         pend_q  <= 16'h0000;
         disp_q  <= 16'h0000;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         disp_q  <= disp_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      idx_d       = idx_q;
      frame_start = 1'b0;
      if (!en) begin
         state_d = ST_OFF;
         presc_d = '0;
         idx_d   = 2'd0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d     = ST_GAP;
               presc_d     = '0;
               idx_d       = 2'd0;
               frame_start = 1'b1;
            end
            ST_GAP: begin
               presc_d = presc_q + PW'(1);
               if (presc_q == GAP_LAST) state_d = ST_ON;
            end
            ST_ON: begin
               if (presc_q == SLOT_LAST) begin
                  presc_d     = '0;
                  idx_d       = idx_q + 2'd1;
                  state_d     = ST_GAP;
                  frame_start = (idx_q == 2'd3);
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            default: begin
               state_d = ST_OFF;
               presc_d = '0;
               idx_d   = 2'd0;
            end
         endcase
      end
   end

   // A load landing on the frame boundary still lets the older value commit;
   // the new value then waits a full frame.
   always_comb begin
      pend_d = pend_q;
      disp_d = disp_q;
      busy_d = busy_q;
      ack_d  = 1'b0;
      if (frame_start && busy_q) begin
         disp_d = pend_q;
         busy_d = 1'b0;
         ack_d  = 1'b1;
      end
      if (load) begin
         pend_d = data_in;
         busy_d = 1'b1;
      end
   end

   assign digit_sel = disp_d[{idx_d, 2'b00} +: 4];

   x7seg u_x7seg (
      .hex (digit_sel),
      .seg (seg_raw)
   );

   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (state_d != ST_OFF) begin
         seg_d = (lz_en && lz_blank(disp_d, idx_d)) ? SEG_BLANK : seg_raw;
         dp_d  = ~dp_in[idx_d];
      end
      if (state_d == ST_ON) an_d = ~(4'b0001 << idx_d);
   end

   assign an     = an_q;
   assign a_to_g = seg_q;
   assign dp     = dp_q;
   assign ack    = ack_q;
   assign busy   = busy_q;

endmodule
